args_distance_mode: RTL and testbench

ARGS_DISTANCE_MODE -- requirements
Module: args_distance_mode

---
 rtl/args_distance_mode_if.sv | 15 +
 rtl/args_distance_mode.sv | 156 +++++++++++++++
 tb/tb_args_distance_mode.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/args_distance_mode_if.sv
// Stream bundle (data, sideband, frame end, valid/ready) shared by the
// input and output sides of args_distance_mode.
interface args_distance_mode_if #(
    parameter int DATA_W = 44,
    parameter int USER_W = 4
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/args_distance_mode.sv
// Distance between two points under a selectable metric (euclidean floor-sqrt,
// squared, manhattan, chebyshev); one beat in flight, sqrt one bit per cycle.
module args_distance_mode #(
    parameter int XW     = 11,
    parameter int YW     = 11,
    parameter int CW     = 4,
    parameter int OFFSET = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cfg_mode,
    args_distance_mode_if.slave  s_axis,
    args_distance_mode_if.master m_axis,
    output logic                 busy
);
    localparam int MAXW = (XW > YW) ? XW : YW;
    localparam int DW   = MAXW + 1;
    localparam int EW   = DW + 1;
    localparam int SW   = 2 * DW + 1;
    localparam int NI   = DW + 1;
    localparam int RW   = 2 * NI;
    localparam int CNTW = $clog2(NI);

    typedef enum logic [1:0] {IDLE, PREP, SQRT, DONE} state_t;

    state_t          state_q;
    logic [SW-1:0]   m_data_q;
    logic [CW-1:0]   m_user_q;
    logic            m_last_q;
    logic            m_valid_q;

    logic [DW-1:0]   dx_q, dy_q;
    logic [1:0]      mode_q;
    logic [RW-1:0]   rad_q;
    logic [NI-1:0]   rem_q;
    logic [NI-1:0]   root_q;
    logic [CNTW-1:0] cnt_q;

    logic [XW-1:0]   x1, x2;
    logic [YW-1:0]   y1, y2;
    logic            s_ready;

    assign y1 = s_axis.tdata[0 +: YW];
    assign x1 = s_axis.tdata[YW +: XW];
    assign y2 = s_axis.tdata[XW + YW +: YW];
    assign x2 = s_axis.tdata[XW + 2 * YW +: XW];

    assign s_ready       = (state_q == IDLE) && !rst;
    assign s_axis.tready = s_ready;
    assign busy          = (state_q != IDLE);

    assign m_axis.tdata  = m_data_q;
    assign m_axis.tuser  = m_user_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tvalid = m_valid_q;

    logic signed [EW-1:0] ex, ey;
    logic [EW-1:0]        ax, ay;
    logic [DW-1:0]        dx_d, dy_d;

    assign ex   = $signed(EW'(x1)) - $signed(EW'(x2)) + EW'(OFFSET);
    assign ey   = $signed(EW'(y1)) - $signed(EW'(y2)) + EW'(OFFSET);
    assign ax   = ex[EW-1] ? EW'(-ex) : EW'(ex);
    assign ay   = ey[EW-1] ? EW'(-ey) : EW'(ey);
    assign dx_d = ax[DW-1:0];
    assign dy_d = ay[DW-1:0];

    logic [SW-1:0] sum_d, res_d;

    always_comb begin
        sum_d = SW'(dx_q) * SW'(dx_q) + SW'(dy_q) * SW'(dy_q);
        res_d = '0;
        case (mode_q)
            2'd1:    res_d = sum_d;
            2'd2:    res_d = SW'(dx_q) + SW'(dy_q);
            2'd3:    res_d = (dx_q > dy_q) ? SW'(dx_q) : SW'(dy_q);
            default: res_d = '0;
        endcase
    end

    // Digit-by-digit root: bring down two radicand bits, try {root,01}.
    // The remainder never exceeds 2*root, so NI bits hold it between steps.
    logic [NI+1:0] rem_sh, trial, rem_d;
    logic          ge;
    logic [NI-1:0] root_d;

    always_comb begin
        rem_sh = {rem_q, rad_q[RW-1 -: 2]};
        trial  = {root_q, 2'b01};
        ge     = (rem_sh >= trial);
        rem_d  = ge ? (rem_sh - trial) : rem_sh;
        root_d = {root_q[NI-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (s_axis.tvalid && s_ready) begin
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            mode_q <= cfg_mode;
        end
        if (state_q == PREP) begin
            rad_q  <= RW'(sum_d);
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == SQRT) begin
            rad_q  <= {rad_q[RW-3:0], 2'b00};
            rem_q  <= NI'(rem_d);
            root_q <= root_d;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_axis.tvalid) begin
                        m_user_q <= s_axis.tuser;
                        m_last_q <= s_axis.tlast;
                        state_q  <= PREP;
                    end
                end
                PREP: begin
                    if (mode_q == 2'd0) begin
                        state_q <= SQRT;
                    end else begin
                        m_data_q  <= res_d;
                        m_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                SQRT: begin
                    if (cnt_q == CNTW'(NI - 1)) begin
                        m_data_q  <= SW'(root_d);
                        m_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (m_axis.tready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_args_distance_mode.sv
// Bench for args_distance_mode: directed vector table, reset corner cases and
// a randomized scoreboard run against an arithmetic reference model.
module tb_args_distance_mode;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int CW = 4;
    localparam int SW = 25;
    localparam int TW = 2 * XW + 2 * YW;
    localparam int NB = 4000;

    logic          clk;
    logic          rst;
    logic [1:0]    cfg_mode;
    logic [TW-1:0] tdata_in;
    logic [CW-1:0] tuser_in;
    logic          tlast_in;
    logic          tvalid_in;
    logic          m_ready_in;
    int            sel;
    logic          busy0, busy1;

    args_distance_mode_if #(.DATA_W(TW), .USER_W(CW)) s0 ();
    args_distance_mode_if #(.DATA_W(SW), .USER_W(CW)) m0 ();
    args_distance_mode_if #(.DATA_W(TW), .USER_W(CW)) s1 ();
    args_distance_mode_if #(.DATA_W(SW), .USER_W(CW)) m1 ();

    args_distance_mode #(.XW(XW), .YW(YW), .CW(CW), .OFFSET(0)) dut0 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
        .s_axis(s0), .m_axis(m0), .busy(busy0)
    );
    args_distance_mode #(.XW(XW), .YW(YW), .CW(CW), .OFFSET(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
        .s_axis(s1), .m_axis(m1), .busy(busy1)
    );

    assign s0.tdata  = tdata_in;
    assign s0.tuser  = tuser_in;
    assign s0.tlast  = tlast_in;
    assign s0.tvalid = tvalid_in && (sel == 0);
    assign s1.tdata  = tdata_in;
    assign s1.tuser  = tuser_in;
    assign s1.tlast  = tlast_in;
    assign s1.tvalid = tvalid_in && (sel == 1);
    assign m0.tready = m_ready_in;
    assign m1.tready = m_ready_in;

    logic          s_ready_w, m_valid_w, m_last_w, busy_w;
    logic [SW-1:0] m_data_w;
    logic [CW-1:0] m_user_w;
    assign s_ready_w = (sel == 1) ? s1.tready : s0.tready;
    assign m_valid_w = (sel == 1) ? m1.tvalid : m0.tvalid;
    assign m_data_w  = (sel == 1) ? m1.tdata  : m0.tdata;
    assign m_user_w  = (sel == 1) ? m1.tuser  : m0.tuser;
    assign m_last_w  = (sel == 1) ? m1.tlast  : m0.tlast;
    assign busy_w    = (sel == 1) ? busy1     : busy0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic longint isqrt(input longint s);
        longint lo = 0, hi = 8192, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= s) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic longint ref_dist(input int x1, input int y1, input int x2,
                                        input int y2, input int mode, input int off);
        longint dx = x1 - x2 + off;
        longint dy = y1 - y2 + off;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        case (mode)
            0:       return isqrt(dx * dx + dy * dy);
            1:       return dx * dx + dy * dy;
            2:       return dx + dy;
            default: return (dx > dy) ? dx : dy;
        endcase
    endfunction

    function automatic logic [TW-1:0] pack(input int x1, input int y1, input int x2, input int y2);
        logic [XW-1:0] a, c;
        logic [YW-1:0] b, d;
        a = x1[XW-1:0];
        b = y1[YW-1:0];
        c = x2[XW-1:0];
        d = y2[YW-1:0];
        return {c, d, a, b};
    endfunction

    typedef struct {
        int     dut;
        int     x1, y1, x2, y2;
        int     mode;
        int     user;
        int     last;
        longint res;
        int     lat;
        int     hold;
    } vec_t;

    // Starts just after a rising edge; returns just after a rising edge with
    // the output beat consumed.
    task automatic send(input vec_t v);
        int            t;
        int            lat;
        logic [SW-1:0] held;
        sel        = v.dut;
        m_ready_in = (v.hold == 0);
        tdata_in   = pack(v.x1, v.y1, v.x2, v.y2);
        tuser_in   = v.user[CW-1:0];
        tlast_in   = v.last[0];
        cfg_mode   = v.mode[1:0];
        tvalid_in  = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_ready_w && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", s_ready_w, 1);
        @(posedge clk);
        #1;
        tvalid_in = 1'b0;
        cfg_mode  = ~v.mode[1:0];
        lat = 1;
        @(negedge clk);
        while (!m_valid_w && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("vec_latency", lat, v.lat);
        chk("vec_data", m_data_w, v.res);
        chk("vec_user_last", {m_user_w, m_last_w}, {v.user[CW-1:0], v.last[0]});
        held = m_data_w;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("bp_valid", m_valid_w, 1);
            chk("bp_data_stable", m_data_w, held);
            chk("bp_side_stable", {m_user_w, m_last_w}, {v.user[CW-1:0], v.last[0]});
            chk("bp_s_ready_low", s_ready_w, 0);
        end
        if (v.hold > 0) begin
            @(posedge clk);
            #1;
            m_ready_in = 1'b1;
            @(negedge clk);
            chk("bp_valid_release", m_valid_w, 1);
        end
        @(posedge clk);
        #1;
        m_ready_in = 1'b1;
    endtask

    typedef struct {
        logic [SW-1:0] data;
        logic [CW-1:0] user;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[16];

    initial begin
        int            vcnt;
        int            sent, got;
        int            cx1, cy1, cx2, cy2;
        logic          acc, stall_prev;
        logic [SW-1:0] prev_data;
        logic [CW-1:0] prev_user;
        logic          prev_last;
        exp_t          e;

        vecs[0]  = '{0, 100, 50, 97, 46, 0, 1, 0, 5, 15, 0};
        vecs[1]  = '{0, 100, 50, 97, 46, 1, 2, 1, 25, 2, 0};
        vecs[2]  = '{0, 100, 50, 97, 46, 2, 3, 0, 7, 2, 0};
        vecs[3]  = '{0, 100, 50, 97, 46, 3, 4, 1, 4, 2, 0};
        vecs[4]  = '{0, 2047, 2047, 0, 0, 1, 5, 0, 8380418, 2, 0};
        vecs[5]  = '{0, 2047, 2047, 0, 0, 0, 6, 1, 2894, 15, 0};
        vecs[6]  = '{0, 2047, 2047, 0, 0, 2, 7, 0, 4094, 2, 0};
        vecs[7]  = '{0, 2047, 2047, 0, 0, 3, 8, 1, 2047, 2, 0};
        vecs[8]  = '{0, 0, 0, 2047, 2047, 1, 9, 0, 8380418, 2, 0};
        vecs[9]  = '{0, 97, 46, 100, 50, 0, 11, 1, 5, 15, 0};
        vecs[10] = '{0, 100, 50, 97, 46, 1, 10, 1, 25, 2, 10};
        vecs[11] = '{1, 10, 10, 10, 10, 1, 12, 0, 2, 2, 0};
        vecs[12] = '{1, 10, 10, 10, 10, 0, 13, 1, 1, 15, 0};
        vecs[13] = '{1, 3, 7, 5, 7, 2, 14, 0, 2, 2, 0};
        vecs[14] = '{1, 5, 7, 3, 7, 1, 15, 1, 10, 2, 0};
        vecs[15] = '{1, 3, 7, 5, 7, 3, 0, 0, 1, 2, 0};

        sel        = 0;
        rst        = 1'b1;
        cfg_mode   = 2'd0;
        tdata_in   = '0;
        tuser_in   = '0;
        tlast_in   = 1'b0;
        tvalid_in  = 1'b0;
        m_ready_in = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", m_valid_w, 0);
        chk("rst_busy", busy_w, 0);
        chk("rst_data", m_data_w, 0);
        chk("rst_side", {m_user_w, m_last_w}, 0);
        chk("rst_s_ready", s_ready_w, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready_w, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) send(vecs[i]);

        // Reset during the fifth square-root cycle must abort the beat.
        sel       = 0;
        tdata_in  = pack(2047, 2047, 0, 0);
        tuser_in  = 4'h5;
        tlast_in  = 1'b1;
        cfg_mode  = 2'd0;
        tvalid_in = 1'b1;
        @(negedge clk);
        chk("abort_accept_ready", s_ready_w, 1);
        @(posedge clk);
        #1;
        tvalid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy_in_sqrt", busy_w, 1);
        chk("abort_s_ready_in_rst", s_ready_w, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_s_ready_after", s_ready_w, 1);
        chk("abort_busy_after", busy_w, 0);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid_w) vcnt++;
            @(negedge clk);
        end
        chk("abort_no_output", vcnt, 0);
        @(posedge clk);
        #1;
        send(vecs[5]);

        // Randomized regression on the OFFSET=0 instance.
        sel        = 0;
        sent       = 0;
        got        = 0;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_user  = '0;
        prev_last  = 1'b0;
        cx1 = 0; cy1 = 0; cx2 = 0; cy2 = 0;
        for (int cyc = 0; cyc < 90000 && got < NB; cyc++) begin
            @(negedge clk);
            if (stall_prev) begin
                chk("rand_stall_stable", {m_valid_w, m_data_w, m_user_w, m_last_w},
                    {1'b1, prev_data, prev_user, prev_last});
            end
            if (tvalid_in && s_ready_w) begin
                e.data = SW'(ref_dist(cx1, cy1, cx2, cy2, int'(cfg_mode), 0));
                e.user = tuser_in;
                e.last = tlast_in;
                exp_q.push_back(e);
                sent++;
            end
            if (m_valid_w && m_ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("rand_extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_data", m_data_w, e.data);
                    chk("rand_side", {m_user_w, m_last_w}, {e.user, e.last});
                end
                got++;
            end
            stall_prev = m_valid_w && !m_ready_in;
            prev_data  = m_data_w;
            prev_user  = m_user_w;
            prev_last  = m_last_w;
            acc        = tvalid_in && s_ready_w;
            @(posedge clk);
            #1;
            if (acc || !tvalid_in) begin
                if (sent < NB && ($urandom % 4) != 0) begin
                    cx1 = ($urandom % 8 == 0) ? 0 : (($urandom % 8 == 0) ? 2047 : int'($urandom_range(0, 2047)));
                    cy1 = ($urandom % 8 == 0) ? 0 : (($urandom % 8 == 0) ? 2047 : int'($urandom_range(0, 2047)));
                    cx2 = ($urandom % 8 == 0) ? 0 : (($urandom % 8 == 0) ? 2047 : int'($urandom_range(0, 2047)));
                    cy2 = ($urandom % 8 == 0) ? 0 : (($urandom % 8 == 0) ? 2047 : int'($urandom_range(0, 2047)));
                    tdata_in  = pack(cx1, cy1, cx2, cy2);
                    tuser_in  = CW'($urandom);
                    tlast_in  = 1'($urandom);
                    tvalid_in = 1'b1;
                end else begin
                    tvalid_in = 1'b0;
                end
            end
            cfg_mode   = 2'($urandom);
            m_ready_in = ($urandom % 3) != 0;
        end
        chk("rand_beats_out", got, NB);
        chk("rand_beats_in", sent, NB);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
